bus_initiator: RTL



---
 rtl/bus_initiator_pkg.sv | 27 ++
 rtl/bus_wait_counter.sv | 34 +++
 rtl/bus_initiator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_initiator_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_initiator_pkg
// Purpose  : Shared types and constants for the 8-bit peripheral bus initiator
// Revision : 1.0 - initial release
// ============================================================================
package bus_initiator_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 8;
    localparam int WAIT_W     = 4;

    localparam logic [BUS_ADDR_W-1:0] DEFAULT_IDLE_ADDR = 8'hFF;
    localparam logic [BUS_ADDR_W-1:0] SEVSEG_LO_ADDR    = 8'hD0;
    localparam logic [BUS_ADDR_W-1:0] SEVSEG_HI_ADDR    = 8'hD1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_wait_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_wait_counter
// Purpose  : Loadable down-counter that paces read cycles; done when zero
// Revision : 1.0 - initial release
// ============================================================================
module bus_wait_counter
    import bus_initiator_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic              done
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_initiator
// Purpose  : Converts single read/write commands into peripheral bus cycles.
//            Define BUS_INITIATOR_READBACK_VERIFY_EN to read back every write.
// Revision : 1.0 - initial release
// ============================================================================
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter logic [BUS_ADDR_W-1:0] IDLE_ADDR = DEFAULT_IDLE_ADDR,
    parameter int                    RD_WAIT   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [BUS_ADDR_W-1:0] cmd_addr,
    input  logic [BUS_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    input  logic                  BUS_GRANT,
    output logic [BUS_ADDR_W-1:0] BUS_ADDR,
    output logic                  BUS_WE,
    inout  wire  [BUS_DATA_W-1:0] BUS_DATA
);

    localparam logic [WAIT_W-1:0] c_rd_wait = WAIT_W'(RD_WAIT);

    state_t                r_state;
    logic [BUS_ADDR_W-1:0] r_addr;
    logic [BUS_DATA_W-1:0] r_wdata;

    logic w_accept;
    logic w_wr_phase;
    logic w_rd_phase;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_done;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_wr_phase = (r_state == ST_WRITE);

`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
    assign w_rd_phase = (r_state == ST_READ) || (r_state == ST_VERIFY);
    assign w_cnt_load = (w_accept && !cmd_we) || (w_wr_phase && BUS_GRANT);
`else
    assign w_rd_phase = (r_state == ST_READ);
    assign w_cnt_load = w_accept && !cmd_we;
`endif

    assign w_cnt_dec = w_rd_phase && BUS_GRANT;

    bus_wait_counter u_wait_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (w_cnt_load),
        .load_value (c_rd_wait),
        .dec        (w_cnt_dec),
        .done       (w_cnt_done)
    );

    // Bus pins fall back to idle the moment grant is withdrawn, not an edge later
    assign cmd_ready = (r_state == ST_IDLE) && BUS_GRANT && !RESET;
    assign busy      = (r_state != ST_IDLE);
    assign BUS_ADDR  = (BUS_GRANT && (w_wr_phase || w_rd_phase)) ? r_addr : IDLE_ADDR;
    assign BUS_WE    = BUS_GRANT && w_wr_phase;
    assign BUS_DATA  = (BUS_GRANT && w_wr_phase) ? r_wdata : 'z;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_state <= cmd_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (!BUS_GRANT) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
                        r_state   <= ST_VERIFY;
`else
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_wdata;
                        rsp_err   <= 1'b0;
`endif
                    end
                end
                ST_READ: begin
                    if (!BUS_GRANT) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (w_cnt_done) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= BUS_DATA;
                        rsp_err   <= 1'b0;
                    end
                end
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
                ST_VERIFY: begin
                    if (!BUS_GRANT) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (w_cnt_done) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= BUS_DATA;
                        rsp_err   <= (BUS_DATA != r_wdata);
                    end
                end
`endif
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
